// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the convolution layer sequencing controller.
package conv_ctrl_pkg;

   localparam int GUARD_MIN   = 2;
   localparam int DEF_N_OPS_W = 32;
   localparam int DEF_ADDR_W  = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Descriptor layout at the default widths.
   typedef struct packed {
      logic [DEF_N_OPS_W-1:0] n_ops;
      logic [DEF_ADDR_W-1:0]  base_addr;
      logic                   last;
   } desc_t;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/down_counter_ld.sv
// Loadable down-counter that saturates at zero and flags the zero state.
module down_counter_ld #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/conv_layer_ctrl.sv
// Layer sequencer driving every dispatcher control input, one descriptor at a time.
// Optional RUN watchdog with sticky wd_err: define CONV_CTRL_WATCHDOG_EN.
//
//   state    | meaning
//   ST_IDLE  | waiting for a descriptor (cfg_ready)
//   ST_LOAD  | load dispatcher accumulators, arm guard count
//   ST_RUN   | issue reads until end_conv_layer (after the guard)
//   ST_DRAIN | let the multiplier/adder pipeline empty
//   ST_DONE  | pulse layer_done / net_done, update layer_idx
module conv_layer_ctrl
   import conv_ctrl_pkg::*;
#(
   parameter int max_n_operations = 32,
   parameter int log_rom_size     = 16,
   parameter int log_max_layers   = 4,
   parameter int drain_cycles     = 4,
   parameter int guard_cycles     = 2
`ifdef CONV_CTRL_WATCHDOG_EN
   , parameter int watchdog_cycles = 65535
`endif
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [max_n_operations-1:0] cfg_n_ops,
   input  logic [log_rom_size-1:0]     cfg_base_addr,
   input  logic                        cfg_last,
   input  logic                        hold,
   input  logic                        end_conv_layer,
   output logic [max_n_operations-1:0] init_n_operations,
   output logic [log_rom_size-1:0]     init_base_addr,
   output logic                        load_n_op,
   output logic                        load_base_addr,
   output logic                        acc_op_en,
   output logic                        acc_addr_en,
   output logic                        read_data,
   output logic                        read_weigth,
   output logic                        busy,
   output logic                        layer_done,
   output logic                        net_done,
   output logic [log_max_layers-1:0]   layer_idx
`ifdef CONV_CTRL_WATCHDOG_EN
   , output logic                      wd_err
`endif
);

   localparam int GUARD_EFF = (guard_cycles < GUARD_MIN) ? GUARD_MIN : guard_cycles;
   localparam int SEQ_MAX   = (GUARD_EFF > drain_cycles - 1) ? GUARD_EFF : drain_cycles - 1;
   localparam int SEQ_W     = cnt_width(SEQ_MAX);
   localparam logic [SEQ_W-1:0] GUARD_VAL = SEQ_W'(GUARD_EFF);
   localparam logic [SEQ_W-1:0] DRAIN_VAL = SEQ_W'(drain_cycles - 1);

   state_t                      state_q;
   logic [max_n_operations-1:0] n_ops_q;
   logic [log_rom_size-1:0]     base_addr_q;
   logic                        last_q;
   logic                        load_q, acc_en_q, read_q;
   logic                        layer_done_q, net_done_q;
   logic [log_max_layers-1:0]   layer_idx_q;

   logic             seq_load, seq_dec, seq_zero;
   logic [SEQ_W-1:0] seq_load_val;
   logic             end_ok, wd_trip, wd_hit, leave_run;

   // One counter serves both phases: guard while in RUN, drain afterwards.
   assign end_ok       = end_conv_layer & seq_zero;
   assign leave_run    = (state_q == ST_RUN) & (end_ok | wd_trip);
   assign seq_load     = (state_q == ST_LOAD) | leave_run;
   assign seq_load_val = (state_q == ST_LOAD) ? GUARD_VAL : DRAIN_VAL;
   assign seq_dec      = (state_q == ST_RUN) | (state_q == ST_DRAIN);

   down_counter_ld #(.W(SEQ_W)) u_seq_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (seq_load),
      .load_val_i (seq_load_val),
      .dec_i      (seq_dec),
      .zero_o     (seq_zero)
   );

`ifdef CONV_CTRL_WATCHDOG_EN
   localparam int WD_W = cnt_width(watchdog_cycles);
   logic wd_zero, wd_err_q, wd_hit_q;

   down_counter_ld #(.W(WD_W)) u_wd_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (state_q == ST_LOAD),
      .load_val_i (WD_W'(watchdog_cycles - 1)),
      .dec_i      ((state_q == ST_RUN) && !hold),
      .zero_o     (wd_zero)
   );

   // A genuine end of layer in the same cycle wins over the watchdog.
   assign wd_trip = wd_zero & ~end_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_err_q <= 1'b0;
         wd_hit_q <= 1'b0;
      end else if (leave_run && wd_trip) begin
         wd_err_q <= 1'b1;
         wd_hit_q <= 1'b1;
      end else if (state_q == ST_DONE) begin
         wd_hit_q <= 1'b0;
      end
   end

   assign wd_hit = wd_hit_q;
   assign wd_err = wd_err_q;
`else
   assign wd_trip = 1'b0;
   assign wd_hit  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         n_ops_q      <= '0;
         base_addr_q  <= '0;
         last_q       <= 1'b0;
         load_q       <= 1'b0;
         acc_en_q     <= 1'b0;
         read_q       <= 1'b0;
         layer_done_q <= 1'b0;
         net_done_q   <= 1'b0;
         layer_idx_q  <= '0;
      end else begin
         load_q       <= 1'b0;
         acc_en_q     <= 1'b0;
         read_q       <= 1'b0;
         layer_done_q <= 1'b0;
         net_done_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (cfg_valid) begin
                  n_ops_q     <= cfg_n_ops;
                  base_addr_q <= cfg_base_addr;
                  last_q      <= cfg_last;
                  if (cfg_n_ops == '0) begin
                     state_q      <= ST_DONE;
                     layer_done_q <= 1'b1;
                     net_done_q   <= cfg_last;
                  end else begin
                     state_q  <= ST_LOAD;
                     load_q   <= 1'b1;
                     acc_en_q <= 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               state_q  <= ST_RUN;
               read_q   <= 1'b1;
               acc_en_q <= ~hold;
            end
            ST_RUN: begin
               if (leave_run) begin
                  state_q <= ST_DRAIN;
               end else begin
                  read_q   <= 1'b1;
                  acc_en_q <= ~hold;
               end
            end
            ST_DRAIN: begin
               if (seq_zero) begin
                  state_q      <= ST_DONE;
                  layer_done_q <= 1'b1;
                  net_done_q   <= last_q & ~wd_hit;
               end
            end
            ST_DONE: begin
               state_q     <= ST_IDLE;
               layer_idx_q <= (last_q || wd_hit) ? '0 : layer_idx_q + 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cfg_ready         = (state_q == ST_IDLE) & ~rst;
   assign busy              = (state_q != ST_IDLE);
   assign init_n_operations = n_ops_q;
   assign init_base_addr    = base_addr_q;
   assign load_n_op         = load_q;
   assign load_base_addr    = load_q;
   assign acc_op_en         = acc_en_q;
   assign acc_addr_en       = acc_en_q;
   assign read_data         = read_q;
   assign read_weigth       = read_q;
   assign layer_done        = layer_done_q;
   assign net_done          = net_done_q;
   assign layer_idx         = layer_idx_q;

endmodule

// File: doc/conv_layer_ctrl.md
Name: conv_layer_ctrl

Overview:
- Sequencing controller that sits directly upstream of the dispatcher and drives all of its control inputs.
- Accepts one layer descriptor at a time over a valid/ready handshake: operation count, ROM base address, last-layer flag.
- Per descriptor it loads the dispatcher accumulators, runs reads until the dispatcher reports end of layer, drains the multiplier pipeline, then signals completion.
- Tracks the layer index and signals end of network.

Parameters:
- max_n_operations, 32, width of the operation count (matches the dispatcher).
- log_rom_size, 16, width of the ROM base address.
- log_max_layers, 4, width of the layer index counter.
- drain_cycles, 4, cycles spent in DRAIN after end of layer (multiplier and adder latency); legal range 1..255.
- guard_cycles, 2, cycles after LOAD during which end_conv_layer is ignored; minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- cfg_valid  in  1  descriptor valid.
- cfg_ready  out  1  controller can accept a descriptor.
- cfg_n_ops  in  max_n_operations  products in the layer.
- cfg_base_addr  in  log_rom_size  first ROM address.
- cfg_last  in  1  descriptor is the final layer.
- hold  in  1  downstream back-pressure; freezes the dispatcher accumulators.
- end_conv_layer  in  1  from the dispatcher.
- init_n_operations  out  max_n_operations  to the dispatcher.
- init_base_addr  out  log_rom_size  to the dispatcher.
- load_n_op  out  1  to the dispatcher.
- load_base_addr  out  1  to the dispatcher.
- acc_op_en  out  1  to the dispatcher.
- acc_addr_en  out  1  to the dispatcher.
- read_data  out  1  to the dispatcher.
- read_weigth  out  1  to the dispatcher.
- busy  out  1  state is not IDLE.
- layer_done  out  1  one-cycle pulse at the end of each layer.
- net_done  out  1  one-cycle pulse at the end of the last layer.
- layer_idx  out  log_max_layers  index of the current or most recent layer.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - All registered outputs, the descriptor registers and layer_idx go to 0.
  - cfg_ready = (state==IDLE) & ~rst.
  - Reset mid-operation abandons the layer immediately, with no layer_done.
- Descriptor registers: init_n_operations and init_base_addr hold the captured descriptor until the next capture.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready, capture the descriptor.
  - If cfg_n_ops==0, go to DONE (no dispatcher activity). Otherwise go to LOAD.
- LOAD (1 cycle):
  - load_n_op=load_base_addr=1.
  - acc_op_en=acc_addr_en=1, needed because the dispatcher clocks are gated.
  - Reads stay at 0.
  - Load the guard counter with guard_cycles. Go to RUN.
- RUN:
  - read_data=read_weigth=1.
  - acc_op_en=acc_addr_en=~hold.
  - The guard counter decrements each cycle down to 0.
  - end_conv_layer is honoured only when the guard counter is 0. This masks the stale end_conv_layer=1 the dispatcher reports after reset or after the previous layer.
  - When end_conv_layer is honoured: go to DRAIN, load the drain counter with drain_cycles-1, and deassert all enables and reads in the same transition.
  - hold has no effect on the transition.
- DRAIN:
  - All dispatcher controls are 0.
  - The counter decrements; at 0 go to DONE.
- DONE (1 cycle):
  - layer_done=1.
  - net_done=cfg_last_q.
  - layer_idx: reset to 0 if cfg_last_q, otherwise increment modulo 2**log_max_layers (wrap is legal and silent).
  - Go to IDLE.
- cfg_valid outside IDLE is ignored; the descriptor must be held until accepted.
- Back-to-back layers: a new descriptor may be accepted in the first IDLE cycle after DONE, so the minimum gap is 1 cycle.
- All outputs except cfg_ready are registered or decoded from registered state; there is no combinational path from input to output.

Optional Feature:
- Macro: CONV_CTRL_WATCHDOG_EN.
- When defined:
  - Extra parameter watchdog_cycles (default 65535) and extra output wd_err.
  - A RUN-cycle counter, held while hold=1, is compared against watchdog_cycles.
  - On overflow: set wd_err (sticky until rst) and force DRAIN → DONE. layer_done still pulses, net_done is suppressed, and layer_idx goes to 0.
- When undefined:
  - No counter and no wd_err port.
  - RUN waits indefinitely.

Decomposition:
- Package conv_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DRAIN, DONE);
  - a descriptor struct (n_ops, base_addr, last);
  - the constant GUARD_MIN=2.
- One sub-module, down_counter_ld: a loadable down-counter with a zero flag, used for the guard and drain counts and reused by the watchdog.

Test Plan:
- Descriptor n_ops=100, base=0x0040, last=1 with end_conv_layer tied 1 → end_conv_layer is ignored for 2 RUN cycles; then DRAIN lasts 4 cycles; layer_done and net_done pulse together; layer_idx=0.
- Three descriptors (n_ops 64, 32, 10; last on the third) with a dispatcher model → layer_idx goes 1, 2, then 0; net_done pulses only after the third; one layer_done per layer.
- hold=1 for 5 cycles mid-RUN → acc_op_en/acc_addr_en are 0 exactly for those cycles; read_data stays 1; no descriptor is lost.
- cfg_n_ops=0 → no load_n_op or read pulse; layer_done is asserted 1 cycle after acceptance.
- rst asserted in DRAIN → next cycle state is IDLE, all outputs are 0, cfg_ready=1 after rst falls, no layer_done.
- With CONV_CTRL_WATCHDOG_EN and watchdog_cycles=20, end_conv_layer held 0 → wd_err rises after 20 RUN cycles, then layer_done, no net_done.
